// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the data-memory port arbiter.
// - Requester indices (also the mux select codes): IFETCH, LSU, DBG.
// - Arbiter FSM state encoding.
// - SEL_W: width of the 3-to-1 mux select.
package cpu_mem_pkg;

  localparam int unsigned SEL_W = 2;

  typedef logic [SEL_W-1:0] sel_t;

  localparam sel_t REQ_IFETCH = 2'd0;
  localparam sel_t REQ_LSU    = 2'd1;
  localparam sel_t REQ_DBG    = 2'd2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/mem_port_arbiter_rr_pick3.sv
// Combinational round-robin picker for three requesters.
// Ports:
//   eligible   [2:0] requesters allowed to win this cycle
//   last_owner [1:0] most recent winner; scanning starts just after it
//   winner     [1:0] first eligible index at last_owner+1, +2, +3 (mod 3)
//   any              at least one requester is eligible
module rr_pick3
  import cpu_mem_pkg::*;
(
  input  logic [2:0]       eligible,
  input  logic [SEL_W-1:0] last_owner,
  output logic [SEL_W-1:0] winner,
  output logic             any
);

  logic [SEL_W-1:0] cand;
  logic             found;

  always_comb begin
    winner = last_owner;
    cand   = '0;
    found  = 1'b0;
    for (int unsigned i = 1; i <= 3; i++) begin
      cand = SEL_W'((32'(last_owner) + i) % 3);
      if (!found && eligible[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
    any = |eligible;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for the single data-memory port.
// Requesters: 0 = instruction fetch, 1 = load/store, 2 = debug/DMA.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   req  [2:0]       level requests, held until ack or err
//   lock [2:0]       owner keeps the port after completion while high
//   mem_ready        memory completed the current access
//   sel  [1:0]       address/write-data mux select (holds when idle)
//   grant[2:0]       one-hot current owner while busy
//   mem_valid        transaction outstanding toward memory
//   ack  [2:0]       one-cycle completion pulse to the owner
//   err  [2:0]       one-cycle watchdog-timeout pulse to the owner
//   busy             arbiter is in BUSY
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned WAIT_LIMIT = 16,
  parameter int unsigned CNT_W      = $clog2(WAIT_LIMIT + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] lock,
  input  logic               mem_ready,
  output logic [SEL_W-1:0]   sel,
  output logic [NUM_REQ-1:0] grant,
  output logic               mem_valid,
  output logic [NUM_REQ-1:0] ack,
  output logic [NUM_REQ-1:0] err,
  output logic               busy
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [SEL_W-1:0] last_owner;
  logic [NUM_REQ-1:0] eligible;
  logic [SEL_W-1:0] winner;
  logic             any;

  // A requester that just got ack/err may still show req for one cycle.
  assign eligible = req & ~(ack | err);

  rr_pick3 u_pick (
    .eligible   (eligible),
    .last_owner (last_owner),
    .winner     (winner),
    .any        (any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      sel        <= REQ_IFETCH;
      grant      <= '0;
      mem_valid  <= 1'b0;
      ack        <= '0;
      err        <= '0;
      busy       <= 1'b0;
      last_owner <= REQ_DBG;
      cnt        <= '0;
    end else begin
      ack <= '0;
      err <= '0;
      case (state)
        ST_IDLE: begin
          if (any) begin
            state      <= ST_BUSY;
            grant      <= NUM_REQ'(1) << winner;
            sel        <= winner;
            mem_valid  <= 1'b1;
            busy       <= 1'b1;
            cnt        <= '0;
            last_owner <= winner;
          end
        end
        ST_BUSY: begin
          if (mem_ready) begin
            ack <= grant;
            if (|(grant & lock & req)) begin
              cnt <= '0;
            end else begin
              state     <= ST_IDLE;
              grant     <= '0;
              mem_valid <= 1'b0;
              busy      <= 1'b0;
            end
          end else if (cnt == CNT_W'(WAIT_LIMIT - 1)) begin
            err       <= grant;
            state     <= ST_IDLE;
            grant     <= '0;
            mem_valid <= 1'b0;
            busy      <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  a_grant_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(grant));
  a_sel_matches: assert property (@(posedge clk) disable iff (!rst_n)
    busy |-> (grant == (NUM_REQ'(1) << sel)));
  a_valid_busy: assert property (@(posedge clk) disable iff (!rst_n)
    mem_valid == busy);
  a_ack_err_excl: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0({ack, err}));

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic       clk;
  logic       rst_n;
  logic [2:0] req;
  logic [2:0] lock;
  logic       mem_ready;
  logic [1:0] sel;
  logic [2:0] grant;
  logic       mem_valid;
  logic [2:0] ack;
  logic [2:0] err;
  logic       busy;

  int unsigned n_vec;
  int unsigned n_bad;

  mem_port_arbiter #(
    .NUM_REQ    (3),
    .WAIT_LIMIT (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .lock      (lock),
    .mem_ready (mem_ready),
    .sel       (sel),
    .grant     (grant),
    .mem_valid (mem_valid),
    .ack       (ack),
    .err       (err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] req;
    logic [2:0] lock;
    logic       rdy;
    logic [1:0] sel;
    logic [2:0] grant;
    logic       valid;
    logic [2:0] ack;
    logic [2:0] err;
    logic       busy;
  } vec_t;

  localparam int NV = 20;
  vec_t tbl[NV];

  task automatic step(input logic [2:0] r, input logic [2:0] l, input logic mr);
    req       = r;
    lock      = l;
    mem_ready = mr;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [1:0] e_sel,
                       input logic [2:0] e_grant, input logic e_valid,
                       input logic [2:0] e_ack, input logic [2:0] e_err,
                       input logic e_busy);
    logic [12:0] act;
    logic [12:0] exp;
    act = {sel, grant, mem_valid, ack, err, busy};
    exp = {e_sel, e_grant, e_valid, e_ack, e_err, e_busy};
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got sel=%b grant=%b valid=%b ack=%b err=%b busy=%b, want sel=%b grant=%b valid=%b ack=%b err=%b busy=%b",
               name, sel, grant, mem_valid, ack, err, busy,
               e_sel, e_grant, e_valid, e_ack, e_err, e_busy);
    end
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    // req, lock, rdy | sel, grant, valid, ack, err, busy
    // round robin with all requesting, from reset (last_owner=2)
    tbl[0]  = '{3'b111, 3'b000, 1'b0, 2'b00, 3'b001, 1'b1, 3'b000, 3'b000, 1'b1};
    tbl[1]  = '{3'b111, 3'b000, 1'b1, 2'b00, 3'b000, 1'b0, 3'b001, 3'b000, 1'b0};
    tbl[2]  = '{3'b111, 3'b000, 1'b0, 2'b01, 3'b010, 1'b1, 3'b000, 3'b000, 1'b1};
    tbl[3]  = '{3'b111, 3'b000, 1'b1, 2'b01, 3'b000, 1'b0, 3'b010, 3'b000, 1'b0};
    tbl[4]  = '{3'b111, 3'b000, 1'b0, 2'b10, 3'b100, 1'b1, 3'b000, 3'b000, 1'b1};
    tbl[5]  = '{3'b111, 3'b000, 1'b1, 2'b10, 3'b000, 1'b0, 3'b100, 3'b000, 1'b0};
    tbl[6]  = '{3'b111, 3'b000, 1'b0, 2'b00, 3'b001, 1'b1, 3'b000, 3'b000, 1'b1};
    tbl[7]  = '{3'b111, 3'b000, 1'b1, 2'b00, 3'b000, 1'b0, 3'b001, 3'b000, 1'b0};
    // single LSU transaction, ack three cycles after grant
    tbl[8]  = '{3'b010, 3'b000, 1'b0, 2'b01, 3'b010, 1'b1, 3'b000, 3'b000, 1'b1};
    tbl[9]  = '{3'b010, 3'b000, 1'b0, 2'b01, 3'b010, 1'b1, 3'b000, 3'b000, 1'b1};
    tbl[10] = '{3'b010, 3'b000, 1'b0, 2'b01, 3'b010, 1'b1, 3'b000, 3'b000, 1'b1};
    tbl[11] = '{3'b010, 3'b000, 1'b1, 2'b01, 3'b000, 1'b0, 3'b010, 3'b000, 1'b0};
    tbl[12] = '{3'b000, 3'b000, 1'b0, 2'b01, 3'b000, 1'b0, 3'b000, 3'b000, 1'b0};
    // mem_ready while idle has no effect
    tbl[13] = '{3'b000, 3'b000, 1'b1, 2'b01, 3'b000, 1'b0, 3'b000, 3'b000, 1'b0};
    // req held one cycle past ack is masked, then re-granted
    tbl[14] = '{3'b001, 3'b000, 1'b0, 2'b00, 3'b001, 1'b1, 3'b000, 3'b000, 1'b1};
    tbl[15] = '{3'b001, 3'b000, 1'b1, 2'b00, 3'b000, 1'b0, 3'b001, 3'b000, 1'b0};
    tbl[16] = '{3'b001, 3'b000, 1'b0, 2'b00, 3'b000, 1'b0, 3'b000, 3'b000, 1'b0};
    tbl[17] = '{3'b001, 3'b000, 1'b0, 2'b00, 3'b001, 1'b1, 3'b000, 3'b000, 1'b1};
    tbl[18] = '{3'b000, 3'b000, 1'b1, 2'b00, 3'b000, 1'b0, 3'b001, 3'b000, 1'b0};
    tbl[19] = '{3'b000, 3'b000, 1'b0, 2'b00, 3'b000, 1'b0, 3'b000, 3'b000, 1'b0};

    rst_n     = 1'b0;
    req       = '0;
    lock      = '0;
    mem_ready = 1'b0;
    #12;
    rst_n = 1'b1;
    #1;
    check("reset", 2'b00, 3'b000, 1'b0, 3'b000, 3'b000, 1'b0);

    for (int i = 0; i < NV; i++) begin
      step(tbl[i].req, tbl[i].lock, tbl[i].rdy);
      check($sformatf("vec%0d", i), tbl[i].sel, tbl[i].grant, tbl[i].valid,
            tbl[i].ack, tbl[i].err, tbl[i].busy);
    end

    // Locked LSU with IFETCH pending: three back-to-back acks, lock dropped
    // before the third, then IFETCH wins.
    step(3'b011, 3'b010, 1'b0);
    check("lock_grant", 2'b01, 3'b010, 1'b1, 3'b000, 3'b000, 1'b1);
    for (int k = 0; k < 2; k++) begin
      step(3'b011, 3'b010, 1'b1);
      check($sformatf("lock_ack%0d", k), 2'b01, 3'b010, 1'b1, 3'b010, 3'b000, 1'b1);
      step(3'b011, 3'b010, 1'b0);
      check($sformatf("lock_hold%0d", k), 2'b01, 3'b010, 1'b1, 3'b000, 3'b000, 1'b1);
    end
    step(3'b011, 3'b000, 1'b1);
    check("lock_last_ack", 2'b01, 3'b000, 1'b0, 3'b010, 3'b000, 1'b0);
    step(3'b011, 3'b000, 1'b0);
    check("lock_next_owner", 2'b00, 3'b001, 1'b1, 3'b000, 3'b000, 1'b1);
    step(3'b000, 3'b000, 1'b1);
    check("lock_next_ack", 2'b00, 3'b000, 1'b0, 3'b001, 3'b000, 1'b0);

    // Watchdog: DBG owner, memory silent, err four cycles after grant.
    step(3'b100, 3'b000, 1'b0);
    check("to_grant", 2'b10, 3'b100, 1'b1, 3'b000, 3'b000, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      step(3'b100, 3'b100, 1'b0);
      check($sformatf("to_wait%0d", k), 2'b10, 3'b100, 1'b1, 3'b000, 3'b000, 1'b1);
    end
    step(3'b100, 3'b100, 1'b0);
    check("to_err", 2'b10, 3'b000, 1'b0, 3'b000, 3'b100, 1'b0);
    step(3'b000, 3'b000, 1'b0);
    check("to_after", 2'b10, 3'b000, 1'b0, 3'b000, 3'b000, 1'b0);

    // mem_ready on the timeout cycle wins over the watchdog.
    step(3'b100, 3'b000, 1'b0);
    check("to2_grant", 2'b10, 3'b100, 1'b1, 3'b000, 3'b000, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      step(3'b100, 3'b000, 1'b0);
      check($sformatf("to2_wait%0d", k), 2'b10, 3'b100, 1'b1, 3'b000, 3'b000, 1'b1);
    end
    step(3'b000, 3'b000, 1'b1);
    check("to2_ack", 2'b10, 3'b000, 1'b0, 3'b100, 3'b000, 1'b0);

    // Asynchronous reset mid-transaction, then fresh arbitration.
    step(3'b010, 3'b000, 1'b0);
    check("rst_pre", 2'b01, 3'b010, 1'b1, 3'b000, 3'b000, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async", 2'b00, 3'b000, 1'b0, 3'b000, 3'b000, 1'b0);
    req = 3'b111;
    @(posedge clk);
    #2;
    check("rst_held", 2'b00, 3'b000, 1'b0, 3'b000, 3'b000, 1'b0);
    rst_n = 1'b1;
    step(3'b111, 3'b000, 1'b0);
    check("rst_regrant", 2'b00, 3'b001, 1'b1, 3'b000, 3'b000, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
